// File: rtl/reg_file_pkg.sv
// Shared constants and the byte-merge helper used by the register file write
// path and its same-cycle bypass.
package reg_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_BYTES      = DEFAULT_DATA_WIDTH / 8;

  // Widest word merge_bytes can handle; callers size-cast in and out of it.
  localparam int MERGE_MAX_WIDTH = 1024;
  localparam int MERGE_MAX_BYTES = MERGE_MAX_WIDTH / 8;

  function automatic logic [MERGE_MAX_WIDTH-1:0] merge_bytes(
    input logic [MERGE_MAX_WIDTH-1:0] oldData,
    input logic [MERGE_MAX_WIDTH-1:0] newData,
    input logic [MERGE_MAX_BYTES-1:0] strb
  );
    logic [MERGE_MAX_WIDTH-1:0] result;
    result = oldData;
    for (int i = 0; i < MERGE_MAX_BYTES; i++) begin
      if (strb[i]) begin
        result[8*i +: 8] = newData[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_busy_tracker.sv
// Per-register busy bits: set by issue-stage alloc, cleared by writeback,
// wiped by flush or reset.
module reg_busy_tracker
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr,
  input  logic                     wen,
  input  logic [ADDR_WIDTH-1:0]    waddr,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busyNext;

  // Later assignments override earlier ones, giving flush > alloc > writeback.
  always_comb begin
    w_busyNext = r_busy;
    if (wen) begin
      w_busyNext[waddr] = 1'b0;
    end
    if (alloc_en) begin
      w_busyNext[alloc_addr] = 1'b1;
    end
    if (flush) begin
      w_busyNext = '0;
    end
    if (ZERO_REG) begin
      w_busyNext[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with byte strobes, strobe-aware bypass,
// optional hardwired zero register and a busy scoreboard for hazard detection.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     raddr1,
  input  logic [ADDR_WIDTH-1:0]     raddr2,
  output logic [DATA_WIDTH-1:0]     rdata1,
  output logic [DATA_WIDTH-1:0]     rdata2,
  output logic                      rbusy1,
  output logic                      rbusy2,
  input  logic                      wen,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      alloc_en,
  input  logic [ADDR_WIDTH-1:0]     alloc_addr,
  input  logic                      flush,
  output logic [2**ADDR_WIDTH-1:0]  busy_vec
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      w_busyVec;
  logic                  w_wenEff;
  logic                  w_hit1;
  logic                  w_hit2;
  logic                  w_isZero1;
  logic                  w_isZero2;
  logic [DATA_WIDTH-1:0] w_merged1;
  logic [DATA_WIDTH-1:0] w_merged2;
  logic [DATA_WIDTH-1:0] w_mergedWr;

  function automatic logic [DATA_WIDTH-1:0] mergeWord(
    input logic [DATA_WIDTH-1:0]   oldData,
    input logic [DATA_WIDTH-1:0]   newData,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    return DATA_WIDTH'(merge_bytes(MERGE_MAX_WIDTH'(oldData),
                                   MERGE_MAX_WIDTH'(newData),
                                   MERGE_MAX_BYTES'(strb)));
  endfunction

  reg_busy_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_busyTracker (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wen        (wen),
    .waddr      (waddr),
    .busy_vec   (w_busyVec)
  );

  assign w_wenEff   = wen && !(ZERO_REG && (waddr == '0));
  assign w_mergedWr = mergeWord(r_regs[waddr], wdata, wstrb);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wenEff) begin
      r_regs[waddr] <= w_mergedWr;
    end
  end

  // Bypass is not gated by rst, so a writeback during reset is still visible.
  always_comb begin
    w_hit1    = wen && (waddr == raddr1);
    w_hit2    = wen && (waddr == raddr2);
    w_isZero1 = ZERO_REG && (raddr1 == '0);
    w_isZero2 = ZERO_REG && (raddr2 == '0);
    w_merged1 = mergeWord(r_regs[raddr1], wdata, wstrb);
    w_merged2 = mergeWord(r_regs[raddr2], wdata, wstrb);

    rdata1 = r_regs[raddr1];
    if (w_isZero1) begin
      rdata1 = '0;
    end else if (w_hit1) begin
      rdata1 = w_merged1;
    end

    rdata2 = r_regs[raddr2];
    if (w_isZero2) begin
      rdata2 = '0;
    end else if (w_hit2) begin
      rdata2 = w_merged2;
    end

    rbusy1 = w_busyVec[raddr1] && !w_hit1 && !w_isZero1;
    rbusy2 = w_busyVec[raddr2] && !w_hit2 && !w_isZero2;
  end

  assign busy_vec = w_busyVec;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the CPU general-purpose register file: configurable width and depth, per-byte write strobes, same-cycle write-to-read bypass honouring strobes, hardwired zero register, and a per-register busy scoreboard for pipelined hazard detection. It sits between decode/issue and writeback. Issue marks destination registers pending, and writeback clears them. Hazard logic reads `rbusy1`/`rbusy2` to stall.

## Interface
- `DATA_WIDTH`, 32, register width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 5, address width; depth is 2**ADDR_WIDTH.
- `ZERO_REG`, 1, 1 = register 0 reads zero and ignores writes and allocs; 0 = register 0 is ordinary.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `raddr1`, `raddr2`  in  ADDR_WIDTH  read addresses.
- `rdata1`, `rdata2`  out  DATA_WIDTH  combinational read data, bypassed.
- `rbusy1`, `rbusy2`  out  1  addressed register has an unresolved pending write.
- `wen`  in  1  write enable (writeback).
- `waddr`  in  ADDR_WIDTH  write address.
- `wdata`  in  DATA_WIDTH  write data.
- `wstrb`  in  DATA_WIDTH/8  byte enables; bit i covers `wdata[8i+7:8i]`.
- `alloc_en`  in  1  issue stage claims `alloc_addr` as pending destination.
- `alloc_addr`  in  ADDR_WIDTH  register to mark busy.
- `flush`  in  1  clear every busy bit (pipeline flush).
- `busy_vec`  out  2**ADDR_WIDTH  registered busy bits, bit n = register n.

## Operation
- **Write:** on a rising edge with `wen` and not `rst`, each byte of `register[waddr]` whose strobe is set takes the `wdata` byte; other bytes hold. If `wstrb` is 0, no change. Writeback clears `busy[waddr]` whether or not strobes are set.
- **Read:** `rdata` equals `register[raddr]`, except when `wen` and `waddr == raddr`. In that case each strobed byte comes from `wdata` and the others from the array (byte-merged bypass).
- **rbusy:** `rbusy` is `busy[raddr]` AND NOT (`wen` AND `waddr == raddr`). A same-cycle writeback resolves the hazard because its data is bypassed. `alloc_en` in the same cycle does not affect `rbusy`; it takes effect from the next cycle.
- **Zero register** (`ZERO_REG`=1): reads of address 0 return 0, `rbusy` is 0, and `busy_vec[0]` is held at 0. Writes, bypass and alloc targeting address 0 are ignored.
- **Busy next-state priority**, per register, highest first:
  1. `rst` → 0.
  2. `flush` → 0; `alloc_en` in the same cycle is ignored.
  3. `alloc_en` → 1 for `alloc_addr`; an alloc wins over a same-cycle writeback to the same address.
  4. `wen` → 0 for `waddr`.
  5. Otherwise hold.
- `flush` does not block writes: array data still updates and the bypass still applies.
- Re-allocating a register that is already busy leaves it at 1. Only single-outstanding-producer tracking is required.

## Timing
- **Reset:** one `rst` cycle clears every register to 0 and every busy bit to 0. During that cycle `wen` and `alloc_en` are ignored.
- **After reset:** `busy_vec` = 0, all `rbusy` = 0, and `rdata` = 0 for every address unless `wen` bypass is active.
- **Reset mid-operation:** any in-flight alloc or write in the `rst` cycle is dropped. The bypass path remains combinational during reset.
- **Latency:**
  - Write to array read: 1 cycle.
  - Write to bypass read: 0 cycles.
  - Alloc to `busy_vec`/`rbusy`: 1 cycle.
  - Writeback clear: 0 cycles on `rbusy`, 1 cycle on `busy_vec`.
- **Both read ports** are fully independent; identical addresses return identical data and busy.

## Structure
- Shared package `reg_file_pkg` holds:
  - Default width and depth constants.
  - A byte-count constant (DATA_WIDTH/8).
  - A byte-merge function `merge_bytes(old, new, strb)`, used by both the write path and the bypass.
- One sub-module, `reg_busy_tracker`:
  - Owns the busy vector and its priority logic (`rst`, `flush`, `alloc`, `wen`).
  - Outputs `busy_vec`.
- The top level instantiates it, alongside the data array and the read/bypass logic.

## Test plan
- **Reset:** write 0xDEADBEEF to r5, then assert `rst` one cycle → read r5 = 0 and `busy_vec` = 0. A `wen` to r6 during `rst` → r6 reads 0 afterwards.
- **Strobed bypass:** r3 = 0x11223344. Same cycle: `wen`, `waddr`=3, `wdata`=0xAABBCCDD, `wstrb`=0b0101, `raddr1`=3 → `rdata1` = 0x11BB33DD that cycle; array holds 0x11BB33DD next cycle.
- **Zero register:** `wen` to r0 with 0xFFFFFFFF, `alloc_en` on r0 → `rdata1`(r0) = 0, `rbusy1` = 0, `busy_vec[0]` = 0, and no bypass of 0xFFFFFFFF.
- **Scoreboard:** `alloc_en` r7 at cycle t → `rbusy2`(r7) = 1 at t+1. `wen` r7 at t+3 → `rbusy2` = 0 in t+3 with bypassed data; `busy_vec[7]` = 0 at t+4.
- **Alloc/writeback collision:** r9 busy; same cycle `alloc_en` r9 and `wen` r9 → `busy_vec[9]` = 1 next cycle.
- **Flush:** r2, r4 and r31 busy; `flush` together with `alloc_en` r8 → `busy_vec` = 0 next cycle, r8 not busy.
